// File: rtl/apb_cmd_master.sv
// apb_cmd_master: valid/ready command port to APB3 master bridge, one transfer at a time.
// Define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait states with PREADY low.
module apb_cmd_master #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state, state_nx;
  logic psel_nx, penable_nx, pwrite_nx, rsp_valid_nx, rsp_err_nx, rsp_timeout_nx;
  logic [ADDR_WIDTH-1:0] paddr_nx;
  logic [DATA_WIDTH-1:0] pwdata_nx, rsp_rdata_nx;
  logic expire;
  assign cmd_ready = state == IDLE;
`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;
  // Held at zero outside ACCESS, so it is already clear on entry.
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) wait_cnt <= '0;
    else wait_cnt <= (state != ACCESS) ? '0 : PREADY ? wait_cnt : wait_cnt + 1'b1;
  assign expire = state == ACCESS && !PREADY && wait_cnt == CW'(TIMEOUT_CYCLES);
`else
  assign expire = 1'b0;
`endif
  always_comb begin
    state_nx       = state;
    psel_nx        = PSEL;
    penable_nx     = PENABLE;
    pwrite_nx      = PWRITE;
    paddr_nx       = PADDR;
    pwdata_nx      = PWDATA;
    rsp_valid_nx   = rsp_valid;
    rsp_rdata_nx   = rsp_rdata;
    rsp_err_nx     = rsp_err;
    rsp_timeout_nx = rsp_timeout;
    case (state)
      IDLE: if (cmd_valid) begin
        state_nx  = SETUP;
        psel_nx   = 1'b1;
        pwrite_nx = cmd_write;
        paddr_nx  = cmd_addr;
        pwdata_nx = cmd_wdata;
      end
      SETUP: begin
        state_nx   = ACCESS;
        penable_nx = 1'b1;
      end
      ACCESS: if (PREADY || expire) begin
        state_nx       = RESP;
        psel_nx        = 1'b0;
        penable_nx     = 1'b0;
        rsp_valid_nx   = 1'b1;
        rsp_rdata_nx   = (PREADY && !PWRITE) ? PRDATA : '0;
        rsp_err_nx     = PREADY ? PSLVERR : 1'b1;
        rsp_timeout_nx = !PREADY;
      end
      RESP: if (rsp_ready) begin
        state_nx     = IDLE;
        rsp_valid_nx = 1'b0;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) begin
      state       <= IDLE;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state       <= state_nx;
      PSEL        <= psel_nx;
      PENABLE     <= penable_nx;
      PWRITE      <= pwrite_nx;
      PADDR       <= paddr_nx;
      PWDATA      <= pwdata_nx;
      rsp_valid   <= rsp_valid_nx;
      rsp_rdata   <= rsp_rdata_nx;
      rsp_err     <= rsp_err_nx;
      rsp_timeout <= rsp_timeout_nx;
    end
endmodule
